// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared parameters, FIFO state type and bit-reversed one-hot decode
package decoder_pkg;

  localparam int IN_W_DEF  = 2;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = 8;

  // Widest code the decode helper supports; callers narrow the result with a cast.
  localparam int MAX_IN_W  = 4;
  localparam int MAX_OUT_W = 1 << MAX_IN_W;
  localparam int IDX_W     = $clog2(MAX_IN_W);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_t;

  // The one-hot bit index is the bit-reversal of the w-bit code, matching the 4:2 encoder.
  function automatic logic [MAX_OUT_W-1:0] bitrev_onehot(input logic [MAX_IN_W-1:0] code,
                                                         input logic en, input int w);
    logic [MAX_IN_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_IN_W; i++) begin
      for (int j = 0; j < MAX_IN_W; j++) begin
        if (i < w && j == w - 1 - i) idx[j[IDX_W-1:0]] = code[i[IDX_W-1:0]];
      end
    end
    bitrev_onehot = en ? (MAX_OUT_W'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/decoder_fifo.sv
// rtl/decoder_fifo.sv - synchronous FIFO with an occupancy counter and EMPTY/PARTIAL/FULL state
module decoder_fifo
  import decoder_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  fifo_state_t   state;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & (state != FULL);
  assign do_pop  = pop & (state != EMPTY);
  assign full    = (state == FULL);
  assign empty   = (state == EMPTY);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      state  <= EMPTY;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case (state)
        EMPTY: begin
          if (do_push) begin
            occ   <= (AW+1)'(1);
            state <= PARTIAL;
          end
        end
        PARTIAL: begin
          if (do_push && !do_pop) begin
            occ   <= occ + (AW+1)'(1);
            state <= (occ + (AW+1)'(1) == (AW+1)'(DEPTH)) ? FULL : PARTIAL;
          end else if (do_pop && !do_push) begin
            occ   <= occ - (AW+1)'(1);
            state <= (occ == (AW+1)'(1)) ? EMPTY : PARTIAL;
          end
        end
        FULL: begin
          if (do_pop) begin
            occ   <= occ - (AW+1)'(1);
            state <= PARTIAL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// rtl/decoder_pipe.sv - streaming code to one-hot decoder with input FIFO and transfer counter
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_code,
  input  logic                   in_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<IN_W)-1:0]   out_onehot,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       out_count
);

  localparam int OUT_W = 1 << IN_W;

  logic [IN_W:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  decoder_fifo #(.W(IN_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_en, in_code}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Head entry is {en, code}; the word is forced to zero when nothing is presented.
  assign out_onehot = out_valid ?
      OUT_W'(bitrev_onehot(MAX_IN_W'(head[IN_W-1:0]), head[IN_W], IN_W)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_count <= '0;
    end else if (cnt_clr) begin
      out_count <= '0;
    end else if (pop && out_count != {CNT_W{1'b1}}) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decoder_pipe.sv
// tb/tb_decoder_pipe.sv - scoreboard bench for decoder_pipe with a narrow-counter twin instance
module tb_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = '0;
  logic       in_en = 1'b0;
  logic       out_ready = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       in_ready, out_valid;
  logic [3:0] out_onehot;
  logic [7:0] out_count;
  logic       in_ready2, out_valid2;
  logic [3:0] out_onehot2;
  logic [1:0] out_count2;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  decoder_pipe #(.IN_W(2), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_en(in_en), .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
    .cnt_clr(cnt_clr), .out_count(out_count)
  );

  decoder_pipe #(.IN_W(2), .DEPTH(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
    .in_en(in_en), .out_valid(out_valid2), .out_ready(out_ready), .out_onehot(out_onehot2),
    .cnt_clr(cnt_clr), .out_count(out_count2)
  );

  function automatic logic [3:0] ref_onehot(input logic [1:0] c, input logic e);
    if (!e) return 4'b0000;
    case (c)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b0010;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %b expected no output", out_onehot);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (out_onehot !== e) begin
          errors++;
          $display("FAIL sb_data: got %b expected %b", out_onehot, e);
        end
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_code  = c;
    in_en    = e;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(ref_onehot(c, e));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (out_valid) check("drain_timeout", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and single word
    out_ready = 1'b1;
    #22 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_onehot", 32'(out_onehot), 32'h0);
    check("rst_count", 32'(out_count), 32'd0);
    send(2'b01, 1'b1);
    check("s1_valid", 32'(out_valid), 32'd1);
    check("s1_onehot", 32'(out_onehot), 32'b0100);
    @(posedge clk); #1;
    check("s1_valid_after", 32'(out_valid), 32'd0);
    check("s1_count", 32'(out_count), 32'd1);

    // Mapping sweep, counter cleared first
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr_count", 32'(out_count), 32'd0);
    send(2'b00, 1'b1);
    send(2'b01, 1'b1);
    send(2'b10, 1'b1);
    send(2'b11, 1'b1);
    send(2'b10, 1'b0);
    wait_drain();
    check("sweep_count", 32'(out_count), 32'd5);
    check("sat_count", 32'(out_count2), 32'd3);

    // Backpressure to FULL
    out_ready = 1'b0;
    send(2'b11, 1'b1);
    check("bp_ready_one", 32'(in_ready), 32'd1);
    send(2'b00, 1'b1);
    check("bp_ready_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_code  = 2'b01;
    in_en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_held", 32'(in_ready), 32'd0);
      check("bp_onehot_held", 32'(out_onehot), 32'b1000);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_second_word", 32'(out_onehot), 32'b0001);
    wait_drain();

    // Simultaneous push and pop at occupancy 1
    out_ready = 1'b0;
    send(2'b01, 1'b1);
    in_valid  = 1'b1;
    in_code   = 2'b10;
    in_en     = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(4'b0010);
    @(negedge clk);
    check("pp_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pp_valid", 32'(out_valid), 32'd1);
    check("pp_onehot", 32'(out_onehot), 32'b0010);
    check("pp_not_full", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    wait_drain();

    // Clear wins over a simultaneous pop
    check("sat_before_clr", 32'(out_count2), 32'd3);
    send(2'b11, 1'b1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr_pop_count", 32'(out_count), 32'd0);
    check("clr_pop_count_sat", 32'(out_count2), 32'd0);
    check("clr_pop_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while FULL
    send(2'b00, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_count", 32'(out_count), 32'd1);
    out_ready = 1'b0;
    send(2'b10, 1'b1);
    send(2'b01, 1'b1);
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_onehot", 32'(out_onehot), 32'h0);
    check("arst_count", 32'(out_count), 32'd0);
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(2'b01, 1'b1);
    check("post_rst_s1_valid", 32'(out_valid), 32'd1);
    check("post_rst_s1_onehot", 32'(out_onehot), 32'b0100);
    @(posedge clk); #1;
    check("post_rst_s1_done", 32'(out_valid), 32'd0);
    check("post_rst_s1_count", 32'(out_count), 32'd1);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Streaming binary-to-one-hot decoder. It is the inverse of the team's 4:2 encoder and uses the same code assignment.
- Accepts codes over a valid/ready handshake and buffers them in a small FIFO.
- Presents a decoded one-hot word downstream over valid/ready.
- Counts completed output transfers.
- Sits between a code producer, such as an encoder or control path, and one-hot select/enable logic.

Parameters:
- IN_W, 2, code width; OUT_W = 2**IN_W is derived as a localparam, not overridable.
- DEPTH, 2, FIFO entries, power of two, ≥ 2.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, producer presents in_code.
- in_ready, output, 1, block can accept a code.
- in_code, input, IN_W, encoded index.
- in_en, input, 1, sampled with in_code; 0 stores a "disabled" entry that decodes to all-zero.
- out_valid, output, 1, out_onehot is valid.
- out_ready, input, 1, consumer accepts out_onehot.
- out_onehot, output, OUT_W, decoded word.
- cnt_clr, input, 1, synchronous clear of out_count.
- out_count, output, CNT_W, saturating count of output transfers.

Behaviour:
- **Reset.** Asserting rst at any time, including mid-transfer, immediately forces:
  - state EMPTY, FIFO pointers 0, occupancy 0;
  - out_valid 0, out_onehot 0, out_count 0, in_ready 1 (once rst is deasserted).
  - Stored entries are discarded. The first active edge after deassertion is a normal cycle.
- **Decode mapping.** The one-hot bit index is the bit-reversal of in_code:
  - For IN_W = 2: 00→0001, 01→0100, 10→0010, 11→1000.
  - Exactly one bit is set when the entry's en = 1; all-zero when en = 0.
- **FIFO entry.** Each entry holds {en, code}, i.e. IN_W+1 bits. Decoding is applied to the head entry, and out_onehot is a pure function of registered state.
- **Handshakes.**
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (state != FULL). It is registered-state only, with no combinational path from out_ready.
  - out_valid = (state != EMPTY). out_onehot = 0 whenever out_valid = 0.
  - out_onehot and out_valid stay stable while out_valid & !out_ready.
- **Latency.** A code pushed at edge k is visible on out_valid/out_onehot after edge k, provided the FIFO was empty. Otherwise it follows FIFO order. Throughput is 1 word/cycle at steady state.
- **State machine** (occupancy occ):
  - EMPTY (occ = 0): push → PARTIAL (or → FULL if DEPTH = 1, which is disallowed).
  - PARTIAL (0 < occ < DEPTH):
    - push & !pop → occ+1, reaching FULL at DEPTH;
    - pop & !push → occ−1, reaching EMPTY at 0;
    - push & pop → occ unchanged, head advances, tail writes.
  - FULL: push is impossible because in_ready = 0; pop → PARTIAL.
  - EMPTY with in_valid & out_ready: only the push happens, since there is no fall-through.
- **Pointers.** Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. Occupancy is tracked in a separate counter of log2(DEPTH)+1 bits.
- **Counter.**
  - out_count increments on each pop and saturates at 2**CNT_W−1.
  - cnt_clr has priority over a simultaneous pop: the result is 0, not 1.
  - The counter is unaffected by in_en; disabled entries still count.
- in_code and in_en are ignored when push = 0.

Decomposition:
- Shared package decoder_pkg holds:
  - localparams for default IN_W/DEPTH/CNT_W;
  - the state enum {EMPTY, PARTIAL, FULL};
  - a function bitrev_onehot(code, en) returning OUT_W bits.
- One natural sub-module, decoder_fifo: parametrised sync FIFO with occupancy/state, exposing push/pop/head/full/empty.
- The top level instantiates decoder_fifo, applies bitrev_onehot to the head, and owns out_count.

Test Plan:
- **Reset and single word.** Pulse rst, then push {en=1, code=01} with out_ready = 1.
  - Before the push: in_ready = 1, out_valid = 0, out_onehot = 0000.
  - After the push edge: out_valid = 1, out_onehot = 0100. After the next edge: out_valid = 0, out_count = 1.
- **Full mapping sweep.** Push codes 00, 01, 10, 11 with en = 1, then code 10 with en = 0, with out_ready held 1.
  - Required outputs in order: 0001, 0100, 0010, 1000, 0000. out_count = 5.
- **Backpressure/full.** With out_ready = 0, push 11 then 00.
  - in_ready falls to 0 after the 2nd push. A 3rd in_valid is not accepted. out_onehot holds 1000.
  - Raising out_ready drains 1000 then 0001. in_ready returns to 1 after the first pop.
- **Simultaneous push/pop in PARTIAL.** Occupancy is 1 (head 01); assert push code 10 and out_ready in the same cycle.
  - Occupancy stays 1 and the next out_onehot = 0010.
- **Counter saturation/clear.** With CNT_W = 2, perform 5 transfers: out_count = 3.
  - Assert cnt_clr together with a pop: out_count = 0.
- **Async reset mid-operation.** With FULL and out_ready = 0, assert rst between clock edges.
  - out_valid, out_onehot and out_count go to 0 immediately, without waiting for a clock edge.
  - After release, in_ready = 1 and the next push behaves as in the "Reset and single word" scenario.
